// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with PLL-lock qualification, an address phase
// for pixel fetch, and sync/enable outputs delayed to line up with returned pixels.
module vga_timing_gen #(
   parameter int   H_VISIBLE   = 640,
   parameter int   H_FRONT     = 16,
   parameter int   H_SYNC      = 96,
   parameter int   H_BACK      = 48,
   parameter int   V_VISIBLE   = 480,
   parameter int   V_FRONT     = 10,
   parameter int   V_SYNC      = 2,
   parameter int   V_BACK      = 33,
   parameter logic SYNC_ACTIVE = 1'b0,
   parameter int   PIPE_DELAY  = 2,
   parameter int   LOCK_WAIT   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       running,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       pix_valid,
   output logic       line_start,
   output logic       frame_start,
   output logic       vga_hs,
   output logic       vga_vs,
   output logic       vga_de
);
   localparam int              LW       = $clog2(LOCK_WAIT + 1);
   localparam logic [LW-1:0]   LOCK_MAX = LW'(LOCK_WAIT);
   localparam logic [9:0]      HV       = 10'(H_VISIBLE);
   localparam logic [9:0]      VV       = 10'(V_VISIBLE);
   localparam logic [9:0]      H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0]      V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [9:0]      HS0      = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0]      HS1      = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]      VS0      = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]      VS1      = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic            IDLE     = ~SYNC_ACTIVE;

   logic [1:0]            sync_q;
   logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
   logic [9:0]            h_q, h_d, v_q, v_d, pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic                  pix_valid_q, pix_valid_d, line_start_q, line_start_d;
   logic                  frame_start_q, frame_start_d, hs_q, hs_d, vs_q, vs_d;
   logic [PIPE_DELAY-1:0] hs_p_q, hs_p_d, vs_p_q, vs_p_d, de_p_q, de_p_d;
   logic [PIPE_DELAY:0]   hs_sh, vs_sh, de_sh;
   logic                  act;

   assign running     = lock_cnt_q == LOCK_MAX;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_valid   = pix_valid_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign vga_hs      = hs_p_q[PIPE_DELAY-1];
   assign vga_vs      = vs_p_q[PIPE_DELAY-1];
   assign vga_de      = de_p_q[PIPE_DELAY-1];

   // A low synchronized lock idles everything on the same edge that drops running.
   always_comb begin
      act           = running && sync_q[1];
      lock_cnt_d    = !sync_q[1] ? '0 : running ? lock_cnt_q : lock_cnt_q + 1'b1;
      h_d           = !act || h_q == H_LAST ? '0 : h_q + 10'd1;
      v_d           = !act ? '0 : h_q != H_LAST ? v_q : v_q == V_LAST ? '0 : v_q + 10'd1;
      pix_valid_d   = act && h_q < HV && v_q < VV;
      pix_x_d       = pix_valid_d ? h_q : '0;
      pix_y_d       = pix_valid_d ? v_q : '0;
      line_start_d  = act && h_q == '0;
      frame_start_d = line_start_d && v_q == '0;
      hs_d          = act && h_q >= HS0 && h_q <= HS1 ? SYNC_ACTIVE : IDLE;
      vs_d          = act && v_q >= VS0 && v_q <= VS1 ? SYNC_ACTIVE : IDLE;
      hs_sh         = {hs_p_q, hs_q};
      vs_sh         = {vs_p_q, vs_q};
      de_sh         = {de_p_q, pix_valid_q};
      hs_p_d        = act ? hs_sh[PIPE_DELAY-1:0] : {PIPE_DELAY{IDLE}};
      vs_p_d        = act ? vs_sh[PIPE_DELAY-1:0] : {PIPE_DELAY{IDLE}};
      de_p_d        = act ? de_sh[PIPE_DELAY-1:0] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q        <= '0;
         lock_cnt_q    <= '0;
         h_q           <= '0;
         v_q           <= '0;
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         pix_valid_q   <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         hs_q          <= IDLE;
         vs_q          <= IDLE;
         hs_p_q        <= {PIPE_DELAY{IDLE}};
         vs_p_q        <= {PIPE_DELAY{IDLE}};
         de_p_q        <= '0;
      end else begin
         sync_q        <= {sync_q[0], pll_locked};
         lock_cnt_q    <= lock_cnt_d;
         h_q           <= h_d;
         v_q           <= v_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         pix_valid_q   <= pix_valid_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         hs_p_q        <= hs_p_d;
         vs_p_q        <= vs_p_d;
         de_p_q        <= de_p_d;
      end
   end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a shrunken raster (16x8 totals) plus a
// default-size instance for real 640x480 line timing.
module tb_vga_timing_gen;
   logic       clk = 1'b0;
   logic       rst, pll_locked;
   logic       s_run, s_pv, s_ls, s_fs, s_hs, s_vs, s_de;
   logic [9:0] s_px, s_py;
   logic       d_run, d_pv, d_ls, d_fs, d_hs, d_vs, d_de;
   logic [9:0] d_px, d_py;
   int         checks = 0, failures = 0;
   int         pv_cnt, ls_cnt, hs_cnt;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
      .SYNC_ACTIVE(1'b0), .PIPE_DELAY(2), .LOCK_WAIT(16)
   ) dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .running(s_run),
      .pix_x(s_px), .pix_y(s_py), .pix_valid(s_pv), .line_start(s_ls),
      .frame_start(s_fs), .vga_hs(s_hs), .vga_vs(s_vs), .vga_de(s_de)
   );

   vga_timing_gen dut_full (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .running(d_run),
      .pix_x(d_px), .pix_y(d_py), .pix_valid(d_pv), .line_start(d_ls),
      .frame_start(d_fs), .vga_hs(d_hs), .vga_vs(d_vs), .vga_de(d_de)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle_chk(input string tag);
      chk({tag, "_run"}, s_run, 0);
      chk({tag, "_pv"}, s_pv, 0);
      chk({tag, "_px"}, s_px, 0);
      chk({tag, "_py"}, s_py, 0);
      chk({tag, "_ls"}, s_ls, 0);
      chk({tag, "_fs"}, s_fs, 0);
      chk({tag, "_hs"}, s_hs, 1);
      chk({tag, "_vs"}, s_vs, 1);
      chk({tag, "_de"}, s_de, 0);
   endtask

   task automatic start_seq(input string tag);
      repeat (17) @(negedge clk);
      chk({tag, "_run17"}, s_run, 0);
      @(negedge clk);
      chk({tag, "_run18"}, s_run, 1);
      chk({tag, "_pv18"}, s_pv, 0);
      @(negedge clk);
      chk({tag, "_fs"}, s_fs, 1);
      chk({tag, "_ls"}, s_ls, 1);
      chk({tag, "_pv"}, s_pv, 1);
      chk({tag, "_px"}, s_px, 0);
      chk({tag, "_py"}, s_py, 0);
   endtask

   initial begin
      rst = 1'b0;
      pll_locked = 1'b1;
      #1 rst = 1'b1;
      #1 idle_chk("reset");
      chk("reset_full_hs", d_hs, 1);
      @(negedge clk) rst = 1'b0;
      start_seq("start");
      pv_cnt = 0;
      ls_cnt = 0;
      for (int k = 0; k < 144; k++) begin
         int h, v, hd, vd;
         logic ep, ede, ehs, evs;
         if (k > 0) @(negedge clk);
         h = k % 16;
         v = (k / 16) % 8;
         ep = h < 8 && v < 4;
         if (k < 128 && s_pv) pv_cnt++;
         if (s_ls) ls_cnt++;
         chk("frm_pv", s_pv, ep);
         chk("frm_px", s_px, ep ? h : 0);
         chk("frm_py", s_py, ep ? v : 0);
         chk("frm_ls", s_ls, h == 0);
         chk("frm_fs", s_fs, h == 0 && v == 0);
         ede = 0; ehs = 1; evs = 1;
         if (k >= 2) begin
            hd = (k - 2) % 16;
            vd = ((k - 2) / 16) % 8;
            ede = hd < 8 && vd < 4;
            ehs = !(hd >= 10 && hd <= 12);
            evs = !(vd >= 5 && vd <= 6);
         end
         chk("frm_de", s_de, ede);
         chk("frm_hs", s_hs, ehs);
         chk("frm_vs", s_vs, evs);
      end
      chk("frame_pv_count", pv_cnt, 32);
      chk("frame_ls_count", ls_cnt, 9);
      pll_locked = 1'b0;
      repeat (2) @(negedge clk);
      chk("drop_run2", s_run, 1);
      chk("drop_px2", s_px, 1);
      chk("drop_py2", s_py, 1);
      @(negedge clk);
      idle_chk("drop3");
      pll_locked = 1'b1;
      start_seq("relock");
      pll_locked = 1'b0;
      @(negedge clk) pll_locked = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_run3", s_run, 0);
      chk("glitch_pv3", s_pv, 0);
      repeat (15) @(negedge clk);
      chk("glitch_run18", s_run, 0);
      @(negedge clk);
      chk("glitch_run19", s_run, 1);
      @(negedge clk);
      chk("glitch_fs", s_fs, 1);
      chk("glitch_px", s_px, 0);
      repeat (3) @(negedge clk);
      chk("pre_rst_px", s_px, 3);
      chk("pre_rst_de", s_de, 1);
      #2 rst = 1'b1;
      #1 idle_chk("midrst");
      @(negedge clk) rst = 1'b0;
      start_seq("rst2");
      hs_cnt = 0;
      for (int k = 0; k < 1700; k++) begin
         int x, xd;
         logic ep, ede, ehs;
         if (k > 0) @(negedge clk);
         x = k % 800;
         ep = x < 640;
         if (!d_hs) hs_cnt++;
         chk("full_pv", d_pv, ep);
         chk("full_px", d_px, ep ? x : 0);
         chk("full_ls", d_ls, x == 0);
         chk("full_fs", d_fs, k == 0);
         ede = 0; ehs = 1;
         if (k >= 2) begin
            xd = (k - 2) % 800;
            ede = xd < 640;
            ehs = !(xd >= 656 && xd <= 751);
         end
         chk("full_de", d_de, ede);
         chk("full_hs", d_hs, ehs);
         chk("full_vs", d_vs, 1);
      end
      chk("full_hs_count", hs_cnt, 192);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 640x480 @ 60 Hz VGA raster timing in the 25.175 MHz pixel-clock domain produced by the VGA PLL (outclk_0). It qualifies the PLL lock indication before starting the raster. It drives pixel coordinates to the framebuffer/pixel source in an address phase. It emits hsync, vsync and display-enable delayed by a fixed pipeline depth so they align with pixel data returned by the downstream fetch path.

## Interface

Parameters:

- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, asserted level of vga_hs/vga_vs (0 = active-low)
- PIPE_DELAY, 2, cycles from address phase to vga_hs/vga_vs/vga_de (range 1..8)
- LOCK_WAIT, 16, consecutive synchronized-locked cycles required before the raster starts

Ports:

- clk  in  1  pixel clock (PLL outclk_0)
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL locked, asynchronous to clk
- running  out  1  raster active
- pix_x  out  10  column in address phase; 0 when not visible
- pix_y  out  10  row in address phase; 0 when not visible
- pix_valid  out  1  address-phase coordinate is inside the visible area
- line_start  out  1  one-cycle pulse, h=0 of every line
- frame_start  out  1  one-cycle pulse, h=0 and v=0
- vga_hs  out  1  horizontal sync, PIPE_DELAY-delayed
- vga_vs  out  1  vertical sync, PIPE_DELAY-delayed
- vga_de  out  1  pix_valid delayed PIPE_DELAY cycles

## Operation

- Lock qualifier:
  - pll_locked passes through a 2-flop synchronizer, giving locked_s.
  - lock_cnt increments while locked_s=1, saturating at LOCK_WAIT.
  - lock_cnt clears on any cycle with locked_s=0.
  - running=1 while lock_cnt==LOCK_WAIT.
- Loss of lock: locked_s=0 clears running on the next edge. Counters return to 0 and all address-phase outputs go idle. The delay pipeline flushes to idle values (it does not drain).
- Counters (run only while running=1):
  - h counts 0..H_TOTAL-1, where H_TOTAL = sum of the four H parameters = 800.
  - v increments when h wraps and counts 0..V_TOTAL-1 (525). v wraps to 0 on the same edge that h wraps from 799 with v=524.
  - Frame length is 420000 cycles.
- Address phase (registered from h/v):
  - pix_valid = (h<H_VISIBLE)&&(v<V_VISIBLE).
  - pix_x=h and pix_y=v when pix_valid=1; both are 0 otherwise.
  - line_start = (h==0); frame_start = (h==0 && v==0).
- Sync windows:
  - hs active for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] (656..751).
  - vs active for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] (490..491).
  - The active level is SYNC_ACTIVE; the idle level is ~SYNC_ACTIVE.
- Output pipeline: hs, vs and pix_valid pass through a PIPE_DELAY-stage shift register to become vga_hs, vga_vs and vga_de.

## Timing

- Reset values:
  - running=0, lock_cnt=0, synchronizer=0, h=v=0.
  - pix_x=pix_y=0, pix_valid=0, line_start=0, frame_start=0, vga_de=0.
  - vga_hs=vga_vs=~SYNC_ACTIVE, including all pipeline stages.
- Raster start:
  - If pll_locked is high before rst deasserts, running rises on the (LOCK_WAIT+2)th rising edge after rst deasserts.
  - In the first running cycle, h=v=0 internally.
  - The address-phase outputs for (0,0) appear one cycle later: pix_valid=1, frame_start=1, line_start=1, pix_x=pix_y=0.
- vga_de for pixel (x,y) asserts exactly PIPE_DELAY cycles after pix_valid for that pixel.
- line_start pulses every 800 cycles; frame_start pulses every 420000 cycles.
- Reset mid-frame takes effect asynchronously: all outputs go to reset values immediately, and the lock wait restarts.
- A pll_locked glitch of one synchronized cycle stops the raster. After that, a full LOCK_WAIT qualification is required before it restarts.

## Test plan

- Reset release with pll_locked=1 -> running rises on edge 18. The first address-phase cycle shows frame_start=1, pix_x=0, pix_y=0, pix_valid=1.
- Free-run one frame -> exactly 640 pix_valid cycles per visible line, 480 visible lines, and 307200 total pix_valid cycles. vga_hs is low for 96 cycles starting at h=656. vga_vs is low for 1600 cycles (2 lines).
- Alignment check -> each vga_de rise trails its pix_valid rise by exactly 2 cycles. Same for vga_hs relative to the internal hs window; pix_x=639 is followed 2 cycles later by the last vga_de=1.
- Drop pll_locked at h=300, v=100 -> running=0 within 3 edges and pix_valid=0. vga_hs/vga_vs return to 1 and vga_de to 0. Re-asserting pll_locked restarts at (0,0) after 18 edges.
- Assert rst mid-line (h=400) -> all outputs take reset values with no clock edge. After release, the sequence matches the first scenario.
- Wrap check at h=799, v=524 -> next address phase shows frame_start=1. No extra or missing line_start pulse occurs across the frame boundary.
